gdo_activation_unit: RTL and testbench
======================================

Name: gdo_activation_unit

Overview:
- Parametrised, multi-cycle fixed-point activation/derivative engine for the general data operator path; signed Q(INT_BITS).(FRAC_BITS) two's-complement data.
- One operand per transaction, selected by a 3-bit mode: linear, binary, sigmoid, tanh, and their derivatives.
- Sigmoid is a 5-term series, then a bit-serial restoring divide, then post-processing.
- Sits between neuron accumulators and the layer output/backprop buffers, with valid/ready on both sides.

Parameters:
- INT_BITS, 8, integer bits including sign.
- FRAC_BITS, 8, fraction bits. Q-format "one" = 1 << FRAC_BITS.
- DATA_W, INT_BITS+FRAC_BITS, derived operand width; must not be overridden.
- TAG_W, 4, width of the sideband tag carried unchanged from input to output.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand valid.
- in_ready  out  1  unit can accept an operand this cycle.
- in_data  in  DATA_W  signed operand x.
- in_mode  in  3  0 linear, 1 binary, 2 sigmoid, 3 tanh, 4 diff_linear, 5 diff_binary, 6 diff_sigmoid, 7 diff_tanh.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid; held until accepted.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_W  signed result.
- out_tag  out  TAG_W  tag of the transaction.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset, sampled on clk while rst_n=0:
  - State goes to IDLE.
  - out_valid=0, out_data=0, out_tag=0, busy=0.
  - All datapath registers clear.
  - Reset mid-operation abandons the transaction; no output is produced for it.
- States: IDLE, SERIES, DIVIDE, POST, DONE.
- in_ready = (state==IDLE) || (state==DONE && out_ready). Accept occurs when in_valid && in_ready. Accept in DONE with out_ready high gives back-to-back operation with no bubble.
- Fast modes (0, 1, 4, 5): accept goes directly to DONE, so out_valid rises 1 cycle after accept.
  - linear: output = x.
  - binary: output = 0 if x<0, else one.
  - diff_linear: output = one.
  - diff_binary: output = 0.
- Sigmoid core, with argument a:
  - a = x for modes 2, 6, 7; a = x<<1 for mode 3 (truncated to DATA_W).
  - Capture: xa=|a|, acc=xa, den=2*one+xa.
  - SERIES runs 5 cycles. Cycles 1–4 each compute acc = mul(acc,xa) >> s with s = 1, 2, 1, 3, then den += acc. Cycle 5 is an idle settle that loads the divider.
  - DIVIDE runs DATA_W cycles, one quotient bit per cycle: q = (one << FRAC_BITS) / den, unsigned restoring, truncated to DATA_W.
  - POST, first cycle: s = (a>0) ? one - q : q.
- POST final value:
  - sigmoid: s.
  - tanh: (s<<1) - one.
  - diff_sigmoid: mul(s, one-s). Needs a second POST cycle.
  - diff_tanh: one - mul(s,s), using sigmoid(x), not 2x. Needs a second POST cycle.
- Latency from accept to out_valid, with DATA_W=16:
  - sigmoid/tanh: 5 + DATA_W + 2 = 23 cycles.
  - diff_sigmoid/diff_tanh: 24 cycles.
  - Latency is fixed and independent of data.
- mul(p,q): full 2*DATA_W signed product; result is bits [DATA_W+FRAC_BITS-1 -: DATA_W], i.e. arithmetic shift right by FRAC_BITS with truncation toward minus infinity. Add, subtract and shift are DATA_W modular unless saturation is enabled.
- |most-negative| wraps to itself unless saturation is enabled.
- DONE: out_data and out_tag are stable while out_valid && !out_ready. in_mode/in_data changes while busy are ignored. den is never 0, since den ≥ 2*one under saturation; the divide-by-zero path is unreachable.

Optional Feature:
- Macro GDO_ACT_SAT_EN.
- Defined:
  - mul, den accumulation, |a| and the tanh shift/subtract saturate to [-(2^(DATA_W-1)), 2^(DATA_W-1)-1].
  - |most-negative| becomes max positive.
  - x<<1 for tanh saturates.
- Undefined: all such operations wrap modulo 2^DATA_W. Area is smaller and there are no comparators.

Test Plan:
- Fast modes, Q8.8: x=0xFF00 in mode 1 gives 0x0000. x=0x0000 in mode 1 gives 0x0100. x=0x1234 in mode 0 gives 0x1234 with out_valid 1 cycle after accept.
- Sigmoid: x=0x0000 gives 0x0080 after 23 cycles. x=0x0100 gives den 0x03B2, q 0x0045, output 0x00BB.
- Derived modes:
  - mode 3, x=0 gives 0x0000 at 23 cycles.
  - mode 6, x=0 gives 0x0040 at 24 cycles.
  - mode 7, x=0 gives 0x00C0 at 24 cycles.
- Handshake: hold out_ready=0 for 10 cycles after out_valid; out_data/out_tag stay stable and in_ready=0. Raise out_ready with in_valid=1; new operand is accepted in the same cycle and tags come out in order.
- Reset: assert rst_n=0 for 1 cycle during DIVIDE. Next cycle shows IDLE, busy=0, out_valid=0, in_ready=1, and the abandoned tag never appears.
- With GDO_ACT_SAT_EN: mode 2, x=0x7F00 gives den 0x7FFF, q 0x0002, output 0x00FE. Without the macro, the output differs and matches the wrap-model reference.

Source files
------------

// File: rtl/gdo_activation_unit.sv
// gdo_activation_unit: multi-cycle fixed-point activation / derivative engine.
// Signed Q(INT_BITS).(FRAC_BITS) data; modes linear, binary, sigmoid, tanh and
// their derivatives. Sigmoid = 5-term series, bit-serial restoring divide, post.
// Optional macro GDO_ACT_SAT_EN: saturating mul, den accumulation, |a| and the
// tanh shift/subtract. Without it those operations wrap modulo 2^DATA_W.
module gdo_activation_unit #(
    parameter int INT_BITS  = 8,
    parameter int FRAC_BITS = 8,
    parameter int DATA_W    = INT_BITS + FRAC_BITS,
    parameter int TAG_W     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic [2:0]               in_mode,
    input  logic [TAG_W-1:0]         in_tag,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [TAG_W-1:0]         out_tag,
    output logic                     busy
);

    typedef enum logic [2:0] {IDLE, SERIES, DIVIDE, POST, DONE} state_t;

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] SER_LAST = CNT_W'(4);
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DATA_W - 1);

    localparam logic signed [DATA_W-1:0] ONE     = DATA_W'(1) << FRAC_BITS;
    localparam logic signed [DATA_W-1:0] TWO_ONE = DATA_W'(2) << FRAC_BITS;
    localparam logic signed [DATA_W-1:0] S_MAX   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] S_MIN   = {1'b1, {(DATA_W-1){1'b0}}};

    // Dividend one<<FRAC_BITS, split into the initial remainder (high half)
    // and the bits shifted in during the divide (low half).
    localparam logic [2*DATA_W-1:0] NUM    = (2*DATA_W)'(1) << (2*FRAC_BITS);
    localparam logic [DATA_W-1:0]   NUM_HI = NUM[2*DATA_W-1 -: DATA_W];
    localparam logic [DATA_W-1:0]   NUM_LO = NUM[DATA_W-1:0];

    function automatic logic signed [DATA_W-1:0] sat_add(
        input logic signed [DATA_W-1:0] p,
        input logic signed [DATA_W-1:0] q
    );
`ifdef GDO_ACT_SAT_EN
        logic [DATA_W:0] sum;
        sum = {p[DATA_W-1], p} + {q[DATA_W-1], q};
        if (sum[DATA_W] != sum[DATA_W-1]) return sum[DATA_W] ? S_MIN : S_MAX;
        return sum[DATA_W-1:0];
`else
        return p + q;
`endif
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_sub(
        input logic signed [DATA_W-1:0] p,
        input logic signed [DATA_W-1:0] q
    );
`ifdef GDO_ACT_SAT_EN
        logic [DATA_W:0] dif;
        dif = {p[DATA_W-1], p} - {q[DATA_W-1], q};
        if (dif[DATA_W] != dif[DATA_W-1]) return dif[DATA_W] ? S_MIN : S_MAX;
        return dif[DATA_W-1:0];
`else
        return p - q;
`endif
    endfunction

    // Q-format multiply: full signed product, arithmetic shift by FRAC_BITS.
    function automatic logic signed [DATA_W-1:0] mul(
        input logic signed [DATA_W-1:0] p,
        input logic signed [DATA_W-1:0] q
    );
        logic signed [2*DATA_W-1:0] prod;
        logic signed [2*DATA_W-1:0] shr;
        prod = {{DATA_W{p[DATA_W-1]}}, p} * {{DATA_W{q[DATA_W-1]}}, q};
        shr  = prod >>> FRAC_BITS;
`ifdef GDO_ACT_SAT_EN
        if (shr > $signed({{DATA_W{1'b0}}, S_MAX})) return S_MAX;
        if (shr < $signed({{DATA_W{1'b1}}, S_MIN})) return S_MIN;
`endif
        return DATA_W'(shr);
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_abs(
        input logic signed [DATA_W-1:0] p
    );
`ifdef GDO_ACT_SAT_EN
        if (p == S_MIN) return S_MAX;
`endif
        return p[DATA_W-1] ? -p : p;
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_shl1(
        input logic signed [DATA_W-1:0] p
    );
`ifdef GDO_ACT_SAT_EN
        if (p[DATA_W-1] != p[DATA_W-2]) return p[DATA_W-1] ? S_MIN : S_MAX;
`endif
        return p <<< 1;
    endfunction

    state_t                     state, state_nxt;
    logic [2:0]                 mode_r;
    logic signed [DATA_W-1:0]   a_r, xa, acc, den, s_reg;
    logic [DATA_W-1:0]          rem, quo;
    logic [CNT_W-1:0]           cnt;
    logic                       phase;
    logic                       accept;

    logic signed [DATA_W-1:0]   fast_res, arg, arg_abs, acc_step;
    logic [1:0]                 step_sh;
    logic [DATA_W:0]            div_shift;
    logic                       div_ge;
    logic [DATA_W-1:0]          div_rem;
    logic                       a_pos;
    logic signed [DATA_W-1:0]   s_now, s_sel, post_res;

    assign accept = in_valid && in_ready;

    // Operand decode at accept time: fast results and the sigmoid argument.
    always_comb begin
        fast_res = '0;
        case (in_mode)
            3'd0:    fast_res = in_data;
            3'd1:    fast_res = in_data[DATA_W-1] ? '0 : ONE;
            3'd4:    fast_res = ONE;
            default: fast_res = '0;
        endcase
        arg     = (in_mode == 3'd3) ? sat_shl1(in_data) : in_data;
        arg_abs = sat_abs(arg);
    end

    // Series term and one restoring-divide step.
    always_comb begin
        step_sh = 2'd1;
        case (cnt[1:0])
            2'd0:    step_sh = 2'd1;
            2'd1:    step_sh = 2'd2;
            2'd2:    step_sh = 2'd1;
            default: step_sh = 2'd3;
        endcase
        acc_step  = mul(acc, xa) >>> step_sh;
        div_shift = {rem, quo[DATA_W-1]};
        div_ge    = div_shift >= {1'b0, den};
        div_rem   = div_ge ? DATA_W'(div_shift - {1'b0, den}) : div_shift[DATA_W-1:0];
    end

    // Post-processing: fold sigmoid by sign, then derive the requested mode.
    always_comb begin
        a_pos    = !a_r[DATA_W-1] && (a_r != '0);
        s_now    = a_pos ? ONE - $signed(quo) : $signed(quo);
        s_sel    = phase ? s_reg : s_now;
        post_res = s_sel;
        case (mode_r)
            3'd3:    post_res = sat_sub(sat_shl1(s_sel), ONE);
            3'd6:    post_res = mul(s_sel, ONE - s_sel);
            3'd7:    post_res = ONE - mul(s_sel, s_sel);
            default: post_res = s_sel;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = in_mode[1] ? SERIES : DONE;
            end
            SERIES: if (cnt == SER_LAST) state_nxt = DIVIDE;
            DIVIDE: if (cnt == DIV_LAST) state_nxt = POST;
            POST:   if (!mode_r[2] || phase) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    if (in_valid) state_nxt = in_mode[1] ? SERIES : DONE;
                    else          state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: capture on accept, then series, divide and post per state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mode_r   <= '0;
            a_r      <= '0;
            xa       <= '0;
            acc      <= '0;
            den      <= '0;
            s_reg    <= '0;
            rem      <= '0;
            quo      <= '0;
            cnt      <= '0;
            phase    <= 1'b0;
            out_data <= '0;
            out_tag  <= '0;
        end else if (accept) begin
            mode_r  <= in_mode;
            out_tag <= in_tag;
            if (!in_mode[1]) begin
                out_data <= fast_res;
            end else begin
                a_r   <= arg;
                xa    <= arg_abs;
                acc   <= arg_abs;
                den   <= sat_add(TWO_ONE, arg_abs);
                cnt   <= '0;
                phase <= 1'b0;
            end
        end else begin
            case (state)
                SERIES: begin
                    if (cnt != SER_LAST) begin
                        acc <= acc_step;
                        den <= sat_add(den, acc_step);
                        cnt <= cnt + 1'b1;
                    end else begin
                        rem <= NUM_HI;
                        quo <= NUM_LO;
                        cnt <= '0;
                    end
                end
                DIVIDE: begin
                    rem <= div_rem;
                    quo <= {quo[DATA_W-2:0], div_ge};
                    cnt <= cnt + 1'b1;
                end
                POST: begin
                    if (!phase) s_reg <= s_now;
                    phase <= 1'b1;
                    if (!mode_r[2] || phase) out_data <= post_res;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gdo_activation_unit.sv
// Directed bench for gdo_activation_unit (Q8.8, TAG_W=4).
module tb_gdo_activation_unit;

    localparam int DW = 16;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [2:0]    in_mode = '0;
    logic [TW-1:0] in_tag = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [TW-1:0] out_tag;
    logic          busy;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    gdo_activation_unit #(.INT_BITS(8), .FRAC_BITS(8), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .busy(busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present one operand at a negedge; returns one negedge after the accept edge.
    task automatic issue(input logic [2:0] m, input logic [DW-1:0] d, input logic [TW-1:0] t);
        @(negedge clk);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_mode = m; in_data = d; in_tag = t;
        @(negedge clk);
        in_valid = 1'b0; in_mode = ~m; in_data = 16'hDEAD; in_tag = ~t;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (lat == 3) begin
                chk("busy_mid", {31'd0, busy}, 32'd1);
                chk("in_ready_mid", {31'd0, in_ready}, 32'd0);
            end
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic xact(input string name, input logic [2:0] m, input logic [DW-1:0] d,
                        input logic [TW-1:0] t, input logic [DW-1:0] exp, input int exp_lat);
        int lat;
        issue(m, d, t);
        wait_valid(lat);
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_data"}, {16'd0, out_data}, {16'd0, exp});
        chk({name, "_tag"}, {28'd0, out_tag}, {28'd0, t});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic seen;

        repeat (3) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_out_data", {16'd0, out_data}, 32'd0);
        chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;

        // fast modes
        xact("bin_neg",  3'd1, 16'hFF00, 4'h1, 16'h0000, 1);
        xact("bin_zero", 3'd1, 16'h0000, 4'h2, 16'h0100, 1);
        xact("bin_pos",  3'd1, 16'h0001, 4'h3, 16'h0100, 1);
        xact("lin",      3'd0, 16'h1234, 4'h4, 16'h1234, 1);
        xact("lin_min",  3'd0, 16'h8000, 4'h5, 16'h8000, 1);
        xact("dlin",     3'd4, 16'h5555, 4'h6, 16'h0100, 1);
        xact("dbin",     3'd5, 16'h7FFF, 4'h7, 16'h0000, 1);

        // sigmoid family
        xact("sig_0",    3'd2, 16'h0000, 4'h8, 16'h0080, 23);
        xact("sig_1",    3'd2, 16'h0100, 4'h9, 16'h00BB, 23);
        xact("sig_m1",   3'd2, 16'hFF00, 4'hA, 16'h0045, 23);
        xact("tanh_0",   3'd3, 16'h0000, 4'hB, 16'h0000, 23);
        xact("tanh_h",   3'd3, 16'h0080, 4'hC, 16'h0076, 23);
        xact("tanh_mh",  3'd3, 16'hFF80, 4'hD, 16'hFF8A, 23);
        xact("dsig_0",   3'd6, 16'h0000, 4'hE, 16'h0040, 24);
        xact("dsig_1",   3'd6, 16'h0100, 4'hF, 16'h0032, 24);
        xact("dtanh_0",  3'd7, 16'h0000, 4'h1, 16'h00C0, 24);
        xact("dtanh_1",  3'd7, 16'h0100, 4'h2, 16'h0078, 24);
`ifdef GDO_ACT_SAT_EN
        xact("sig_big",  3'd2, 16'h7F00, 4'h3, 16'h00FE, 23);
        xact("sig_min",  3'd2, 16'h8000, 4'h4, 16'h0002, 23);
`else
        xact("sig_big",  3'd2, 16'h7F00, 4'h3, 16'h00FF, 23);
        xact("sig_min",  3'd2, 16'h8000, 4'h4, 16'h0001, 23);
`endif

        // output back-pressure, then back-to-back accept from DONE
        issue(3'd2, 16'h0100, 4'h5);
        wait_valid(lat);
        chk("hold_lat", lat, 23);
        repeat (10) begin
            @(negedge clk);
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_data", {16'd0, out_data}, 32'h00BB);
            chk("hold_tag", {28'd0, out_tag}, 32'h5);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b1; in_mode = 3'd0; in_data = 16'h1234; in_tag = 4'h6;
        out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0;
        chk("b2b_valid", {31'd0, out_valid}, 32'd1);
        chk("b2b_data", {16'd0, out_data}, 32'h1234);
        chk("b2b_tag", {28'd0, out_tag}, 32'h6);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // reset during DIVIDE abandons the transaction
        issue(3'd2, 16'h0100, 4'h9);
        repeat (10) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_data", {16'd0, out_data}, 32'd0);
        chk("mid_rst_tag", {28'd0, out_tag}, 32'd0);
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk("no_ghost", {31'd0, seen}, 32'd0);
        xact("post_rst", 3'd0, 16'h0042, 4'hA, 16'h0042, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
